// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus data-memory port of the
// load/store unit, bundled as one interface.
//   slave  : the LSU side (takes requests, drives response and memory controls)
//   master : the core + memory side (drives requests and mem_read_data)
// Signals:
//   req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata  request
//   resp_valid/resp_rdata/resp_err                               response pulse
//   mem_we/mem_read_addr/mem_write_addr/mem_write_data           memory controls
//   mem_read_data                                                memory read data (1-cycle registered)
interface load_store_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_read_addr, mem_write_addr, mem_write_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_we, mem_read_addr, mem_write_addr, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: converts RISC-V B/H/W/BU/HU loads and B/H/W stores into
// word accesses on a word-addressed memory with 1-cycle registered read.
// Sub-word stores are done as read-modify-write; sub-word loads are lane
// extracted and sign/zero extended. One request in flight; one-cycle
// response pulse issued while already back in IDLE (back-to-back capable).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    load_store_unit_if.slave (request, response, memory port)
// Optional build macro:
//   LSU_MISALIGN_CHECK_EN  when defined, misaligned H/HU/SH and W/SW requests
//                          are rejected with resp_err; otherwise low address
//                          bits below the access size are ignored.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LD, S_RMW_WR, S_WR, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic        req_ready;
  logic        f3_ok, misalign, req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign req_ready = (state_q == S_IDLE);

  // Request decode (only consulted when req_valid is high in IDLE)
  always_comb begin
    f3_ok    = 1'b0;
    misalign = 1'b0;
    if (bus.req_store)
      f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010);
    else
      f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
              (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
              (bus.req_funct3 == 3'b101);
`ifdef LSU_MISALIGN_CHECK_EN
    // funct3[1:0] encodes size for every supported op: 00 B, 01 H, 10 W
    case (bus.req_funct3[1:0])
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = (bus.req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
    req_err = !f3_ok || misalign;
  end

  // Lane extraction from the word returned by memory
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = bus.mem_read_data[7:0];
      2'b01:   byte_sel = bus.mem_read_data[15:8];
      2'b10:   byte_sel = bus.mem_read_data[23:16];
      default: byte_sel = bus.mem_read_data[31:24];
    endcase
    half_sel = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  // Store merge: replace the addressed lane(s) of the word just read
  always_comb begin
    merged = bus.mem_read_data;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0]  = wdata_q[15:0];
    end
  end

  // Next-state and response logic
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_err)
            state_d = S_ERR;
          else if (bus.req_store && (bus.req_funct3 == 3'b010))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      // memory samples the read address at the end of RD
      S_RD: state_d = store_q ? S_RMW_WR : S_LD;
      S_LD: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
      end
      S_RMW_WR, S_WR: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
      end
      S_ERR: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Request capture on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else if (bus.req_valid && req_ready) begin
      store_q  <= bus.req_store;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end
  end

  // Write enable is decoded from state so reset kills a pending write at once
  assign bus.req_ready      = req_ready;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_we         = (state_q == S_WR) || (state_q == S_RMW_WR);
  assign bus.mem_read_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_write_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_write_data = (state_q == S_RMW_WR) ? merged : wdata_q;

endmodule
